io_tty: RTL and testbench
=========================

# io_tty

Console teletype I/O device responder on the KV10 I/O bus, device code 120 (field value 7'o024). It answers DATAI, DATAO, CONI, CONO, CONSZ and CONSO cycles issued by the CPU after instruction decode. It moves characters to and from an external byte-wide serial front end and raises a priority-interrupt request on the programmed PI level. Flag and interrupt behaviour follows the PDP-10 "busy/done" device model.

## Interface
- DEVICE, 7'o024, device-code field matched against io_dev[9:15]
- clk  in  1  system clock; all state changes on rising edge
- reset_n  in  1  asynchronous, active-low reset
- io_dev  in  18 [0:17]  I/O address: {9'b0, device[7], 1'b0, cond}; cond=1 selects CONO/CONI, 0 selects DATAO/DATAI
- io_write  in  1  one-cycle strobe: CONO (cond=1) or DATAO (cond=0)
- io_read  in  1  one-cycle strobe: CONI/CONSZ/CONSO (cond=1) or DATAI (cond=0)
- io_dataw  in  36 [0:35]  write data
- io_datar  out  36 [0:35]  read data; zero when not acking (wired-OR bus)
- io_ack  out  1  one-cycle acknowledge
- pi_req  out  7 [1:7]  one-hot interrupt request per PI level
- tx_data  out  8  output character
- tx_valid  out  1  character offered to front end
- tx_ready  in  1  front end accepts when tx_valid & tx_ready
- rx_data  in  8  input character
- rx_valid  in  1  front end offers character
- rx_ready  out  1  block accepts when rx_valid & rx_ready

## Operation
- Selected when io_dev[9:15]==DEVICE and io_dev[0:8]==0 and io_dev[16]==0; unselected strobes are ignored, no ack.
- Status word (CONI, right half; left half zero): bits 33-35 PIA, 32 output done (0o10), 31 output busy (0o20), 30 input done (0o40), 29 input busy (0o100), 26 overrun (0o1000, only with macro).
- CONO: PIA <= io_dataw[33:35]; 0o10 clears output done; 0o20 clears input done; 0o200 sets output done; 0o400 clear-all (clears all flags, PIA and overrun, after PIA load).
- DATAO: if output busy clear: tx buffer <= io_dataw[28:35], busy=1, done=0. If busy set: acked, data dropped, flags unchanged.
- Transmit FSM: TX_IDLE -> TX_SEND on DATAO accept; tx_valid=1 in TX_SEND; on tx_valid&tx_ready -> TX_IDLE, busy=0, done=1.
- DATAI: io_datar[28:35] = rx buffer, other bits 0; clears input done.
- Receive: rx_ready = !input done. On accept: rx buffer <= rx_data, input done=1. Input busy mirrors rx_valid & !input done.
- pi_req[PIA] = (input done | output done) & PIA!=0; all other bits 0.
- Priority, same cycle: hardware set beats software clear of the same flag; CONO clear-all beats everything. Clear-all during TX_SEND does not drop tx_valid; the character completes, busy clears, and done stays 0.
- Reset: io_ack=0, io_datar=0, pi_req=0, tx_valid=0, tx_data=0, rx_ready=1, all flags/PIA/buffers 0, FSM TX_IDLE.

## Timing
- io_ack asserted exactly one cycle after a selected strobe, for one cycle; io_datar is valid only in the ack cycle.
- Register effects of CONO/DATAO/DATAI are visible in the ack cycle. A CONI in the next strobe sees them.
- Strobes are single-cycle, at most one outstanding; a strobe in the ack cycle is legal and acked the following cycle.
- tx_valid rises in the ack cycle of DATAO. tx_data is stable while tx_valid=1.
- pi_req is registered and reflects flags one cycle after they change.
- rx accept to input done: same edge. rx_ready falls the following cycle.

## Configuration
- IO_TTY_OVERRUN_EN defined: rx_ready is held 1. A character arriving while input done=1 overwrites the rx buffer and sets overrun (0o1000). Overrun is cleared by CONO 0o20 or clear-all.
- Undefined: rx_ready = !input done, back-pressuring the front end; bit 26 reads 0.

## Test plan
- Reset then CONI -> io_ack one cycle later, io_datar=0, pi_req=0, rx_ready=1.
- CONO 0o3, then DATAO 0o101 with tx_ready=0 for 5 cycles then 1 -> tx_data=8'o101 held; on accept CONI=0o13; pi_req[3]=1 the next cycle.
- rx_valid with rx_data=8'h5A -> CONI=0o43 (PIA 3); DATAI returns 36'o132; following CONI=0o03 with output done cleared via CONO 0o10.
- DATAO while busy, value 0o102 -> acked, tx_data stays 0o101; CONO 0o400 mid-send -> character completes, CONI=0.
- Second rx byte 8'h11 while input done: without macro rx_ready=0 and the buffer keeps 8'h5A; with IO_TTY_OVERRUN_EN the buffer becomes 8'h11 and CONI bit 0o1000 is set.
- Strobe with device 7'o025 -> no ack, io_datar=0; assert reset_n low during TX_SEND -> tx_valid=0 immediately.

Source files
------------

// File: rtl/io_tty.sv
// io_tty: console teletype responder on the KV10 I/O bus, device code 7'o024.
//
// It answers CONO/CONI/DATAO/DATAI cycles and moves bytes to and from a byte-wide
// serial front end over valid/ready handshakes. It also raises a one-hot PI request
// on the programmed level while either done flag is set.
//
// Ports:
//   clk, reset_n        clock, asynchronous active-low reset
//   io_dev[0:17]        I/O address {9'b0, device[7], 1'b0, cond}
//   io_write, io_read   single-cycle bus strobes
//   io_dataw[0:35]      write data (bit 35 is the least significant)
//   io_datar[0:35]      read data, zero outside the ack cycle
//   io_ack              one-cycle acknowledge, one cycle after a selected strobe
//   pi_req[1:7]         registered interrupt request on the PIA level
//   tx_data/valid/ready output character handshake
//   rx_data/valid/ready input character handshake
//
// Build option: define IO_TTY_OVERRUN_EN to keep rx_ready high. A byte that arrives
// while input done is set then overwrites the buffer and sets the overrun flag (0o1000).
module io_tty (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [0:17] io_dev,
  input  logic        io_write,
  input  logic        io_read,
  input  logic [0:35] io_dataw,
  output logic [0:35] io_datar,
  output logic        io_ack,
  output logic [1:7]  pi_req,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready
);

  localparam logic [6:0] DEVICE = 7'o024;

  typedef enum logic {TxIdle, TxSend} tx_state_e;

  tx_state_e   tx_state_q, tx_state_d;
  logic [2:0]  pia_q, pia_d;
  logic        out_done_q, out_done_d;
  logic        in_done_q, in_done_d;
  // Set by clear-all while a character is in flight, so its completion leaves done at 0.
  logic        tx_kill_q, tx_kill_d;
  logic [7:0]  tx_buf_q, tx_buf_d;
  logic [7:0]  rx_buf_q, rx_buf_d;
  logic        ack_q, ack_d;
  logic [35:0] datar_q, datar_d;
  logic [1:7]  pi_q, pi_d;
`ifdef IO_TTY_OVERRUN_EN
  logic        overrun_q, overrun_d;
`endif

  // Numeric view of the write data: wdata[0] is bus bit 35.
  logic [35:0] wdata;
  assign wdata = io_dataw;

  logic unused_wdata;
  assign unused_wdata = ^wdata[35:9];

  logic sel, cond, cono, datao, datai, rd_sel;
  logic clear_all, tx_fire, rx_accept, out_busy;
  logic [35:0] status;

  assign sel    = (io_dev[0:8] == 9'd0) && (io_dev[9:15] == DEVICE) && !io_dev[16];
  assign cond   = io_dev[17];
  assign cono   = sel && io_write && cond;
  assign datao  = sel && io_write && !cond;
  assign datai  = sel && io_read && !cond;
  assign rd_sel = sel && io_read;

  assign clear_all = cono && wdata[8];
  assign out_busy  = (tx_state_q == TxSend);
  assign tx_fire   = out_busy && tx_ready;
  assign rx_accept = rx_valid && rx_ready;

`ifdef IO_TTY_OVERRUN_EN
  assign rx_ready = 1'b1;
`else
  assign rx_ready = !in_done_q;
`endif

  assign tx_valid = out_busy;
  assign tx_data  = tx_buf_q;
  assign io_ack   = ack_q;
  assign io_datar = datar_q;
  assign pi_req   = pi_q;

  always_comb begin
    status    = '0;
    status[2:0] = pia_q;
    status[3] = out_done_q;
    status[4] = out_busy;
    status[5] = in_done_q;
    status[6] = rx_valid && !in_done_q;
`ifdef IO_TTY_OVERRUN_EN
    status[9] = overrun_q;
`endif
  end

  // Next-state: software effects first, hardware sets override them, clear-all overrides all.
  always_comb begin
    tx_state_d = tx_state_q;
    pia_d      = pia_q;
    out_done_d = out_done_q;
    in_done_d  = in_done_q;
    tx_kill_d  = tx_kill_q;
    tx_buf_d   = tx_buf_q;
    rx_buf_d   = rx_buf_q;
`ifdef IO_TTY_OVERRUN_EN
    overrun_d  = overrun_q;
`endif

    if (cono) begin
      pia_d = wdata[2:0];
      if (wdata[3]) out_done_d = 1'b0;
      if (wdata[4]) begin
        in_done_d = 1'b0;
`ifdef IO_TTY_OVERRUN_EN
        overrun_d = 1'b0;
`endif
      end
      if (wdata[7]) out_done_d = 1'b1;
    end

    // A DATAO while busy is acked but the byte is dropped.
    if (datao && (tx_state_q == TxIdle)) begin
      tx_buf_d   = wdata[7:0];
      tx_state_d = TxSend;
      out_done_d = 1'b0;
      tx_kill_d  = 1'b0;
    end

    if (datai) in_done_d = 1'b0;

    if (tx_fire) begin
      tx_state_d = TxIdle;
      tx_kill_d  = 1'b0;
      if (!tx_kill_q) out_done_d = 1'b1;
    end

    if (rx_accept) begin
      rx_buf_d  = rx_data;
      in_done_d = 1'b1;
`ifdef IO_TTY_OVERRUN_EN
      if (in_done_q) overrun_d = 1'b1;
`endif
    end

    if (clear_all) begin
      pia_d      = 3'd0;
      out_done_d = 1'b0;
      in_done_d  = 1'b0;
`ifdef IO_TTY_OVERRUN_EN
      overrun_d  = 1'b0;
`endif
      if (out_busy && !tx_fire) tx_kill_d = 1'b1;
    end
  end

  // Bus response and interrupt request, registered.
  always_comb begin
    ack_d   = sel && (io_read || io_write);
    datar_d = '0;
    if (rd_sel) datar_d = cond ? status : {28'd0, rx_buf_q};
    pi_d = '0;
    for (int i = 1; i <= 7; i++) begin
      pi_d[i] = (in_done_q || out_done_q) && (pia_q == 3'(i));
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tx_state_q <= TxIdle;
      pia_q      <= 3'd0;
      out_done_q <= 1'b0;
      in_done_q  <= 1'b0;
      tx_kill_q  <= 1'b0;
      tx_buf_q   <= 8'd0;
      rx_buf_q   <= 8'd0;
      ack_q      <= 1'b0;
      datar_q    <= '0;
      pi_q       <= '0;
`ifdef IO_TTY_OVERRUN_EN
      overrun_q  <= 1'b0;
`endif
    end else begin
      tx_state_q <= tx_state_d;
      pia_q      <= pia_d;
      out_done_q <= out_done_d;
      in_done_q  <= in_done_d;
      tx_kill_q  <= tx_kill_d;
      tx_buf_q   <= tx_buf_d;
      rx_buf_q   <= rx_buf_d;
      ack_q      <= ack_d;
      datar_q    <= datar_d;
      pi_q       <= pi_d;
`ifdef IO_TTY_OVERRUN_EN
      overrun_q  <= overrun_d;
`endif
    end
  end

endmodule

// File: tb/tb_io_tty.sv
// Bench for io_tty: directed walk through the console scenarios, then random bus and
// front-end traffic, all checked every cycle against a flag-level behavioural model.
module tb_io_tty;

`ifdef IO_TTY_OVERRUN_EN
  localparam bit OvrEn = 1'b1;
`else
  localparam bit OvrEn = 1'b0;
`endif
  localparam logic [6:0] Dev = 7'o024;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [0:17] io_dev;
  logic        io_write, io_read;
  logic [0:35] io_dataw;
  logic [0:35] io_datar;
  logic        io_ack;
  logic [1:7]  pi_req;
  logic [7:0]  tx_data;
  logic        tx_valid, tx_ready;
  logic [7:0]  rx_data;
  logic        rx_valid, rx_ready;

  logic [6:0] pi_vec;
  assign pi_vec = pi_req;

  always #5 clk = ~clk;

  io_tty dut (
    .clk     (clk),
    .reset_n (reset_n),
    .io_dev  (io_dev),
    .io_write(io_write),
    .io_read (io_read),
    .io_dataw(io_dataw),
    .io_datar(io_datar),
    .io_ack  (io_ack),
    .pi_req  (pi_req),
    .tx_data (tx_data),
    .tx_valid(tx_valid),
    .tx_ready(tx_ready),
    .rx_data (rx_data),
    .rx_valid(rx_valid),
    .rx_ready(rx_ready)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [35:0] got, input logic [35:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 'o%0o, expected 'o%0o", tag, got, exp);
    end
  endtask

  // Behavioural model: device flags and buffers, plus expected registered outputs.
  int unsigned m_pia;
  bit          m_odone, m_idone, m_ovr, m_send, m_kill;
  logic [7:0]  m_tx, m_rx;
  bit          exp_ack;
  logic [35:0] exp_datar;
  logic [6:0]  exp_pi;

  task automatic model_reset();
    m_pia = 0; m_odone = 0; m_idone = 0; m_ovr = 0; m_send = 0; m_kill = 0;
    m_tx = 8'd0; m_rx = 8'd0;
    exp_ack = 0; exp_datar = '0; exp_pi = '0;
  endtask

  function automatic logic [35:0] m_status();
    int unsigned s;
    s = m_pia;
    if (m_odone) s += 'o10;
    if (m_send) s += 'o20;
    if (m_idone) s += 'o40;
    if (rx_valid && !m_idone) s += 'o100;
    if (OvrEn && m_ovr) s += 'o1000;
    return 36'(s);
  endfunction

  // Applied once per rising edge using the inputs the DUT sampled.
  task automatic model_step();
    logic [35:0] w;
    logic [17:0] dv;
    bit hit, rd, wr, c, was_idone, was_send;
    w  = io_dataw;
    dv = io_dev;
    hit = ((dv & ~18'd1) == (18'(Dev) << 2));
    c  = dv[0];
    rd = hit && io_read;
    wr = hit && io_write;
    was_idone = m_idone;
    was_send  = m_send;

    exp_pi    = (m_pia != 0 && (m_idone || m_odone)) ? 7'(1 << (7 - m_pia)) : 7'd0;
    exp_ack   = rd || wr;
    exp_datar = !rd ? 36'd0 : (c ? m_status() : 36'(m_rx));

    if (wr && c) begin
      m_pia = w % 8;
      if ((w & 'o10) != 0) m_odone = 0;
      if ((w & 'o20) != 0) begin m_idone = 0; m_ovr = 0; end
      if ((w & 'o200) != 0) m_odone = 1;
    end
    if (wr && !c && !was_send) begin
      m_tx = w[7:0]; m_send = 1; m_odone = 0; m_kill = 0;
    end
    if (rd && !c) m_idone = 0;
    if (was_send && tx_ready) begin
      m_send = 0;
      if (!m_kill) m_odone = 1;
      m_kill = 0;
    end
    if (rx_valid && (OvrEn || !was_idone)) begin
      if (was_idone) m_ovr = 1;
      m_rx = rx_data;
      m_idone = 1;
    end
    if (wr && c && ((w & 'o400) != 0)) begin
      m_pia = 0; m_odone = 0; m_idone = 0; m_ovr = 0;
      if (m_send) m_kill = 1;
    end
  endtask

  task automatic compare_all();
    check("ack", 36'(io_ack), 36'(exp_ack));
    check("datar", io_datar, exp_datar);
    check("pi_req", 36'(pi_vec), 36'(exp_pi));
    check("tx_valid", 36'(tx_valid), 36'(m_send));
    check("tx_data", 36'(tx_data), 36'(m_tx));
    check("rx_ready", 36'(rx_ready), 36'(OvrEn ? 1'b1 : !m_idone));
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_all();
    io_read  = 1'b0;
    io_write = 1'b0;
  endtask

  task automatic strobe(input bit rd, input logic [6:0] d, input bit c, input logic [35:0] w);
    io_dev   = {9'd0, d, 1'b0, c};
    io_read  = rd;
    io_write = !rd;
    io_dataw = w;
    tick();
  endtask

  task automatic cono(input logic [35:0] w);  strobe(1'b0, Dev, 1'b1, w); endtask
  task automatic datao(input logic [35:0] w); strobe(1'b0, Dev, 1'b0, w); endtask
  task automatic coni();                      strobe(1'b1, Dev, 1'b1, '0); endtask
  task automatic datai();                     strobe(1'b1, Dev, 1'b0, '0); endtask

  initial begin
    logic [35:0] wv;
    reset_n = 1'b0;
    io_dev = '0; io_write = 1'b0; io_read = 1'b0; io_dataw = '0;
    tx_ready = 1'b0; rx_data = 8'd0; rx_valid = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    compare_all();

    // Reset state read back.
    coni();
    check("rst_coni_ack", 36'(io_ack), 36'd1);
    check("rst_coni_data", io_datar, 36'd0);
    check("rst_pi", 36'(pi_vec), 36'd0);
    check("rst_rx_ready", 36'(rx_ready), 36'd1);

    // Output a character against a stalled front end.
    cono(36'o3);
    datao(36'o101);
    repeat (5) tick();
    check("tx_hold_data", 36'(tx_data), 36'o101);
    check("tx_hold_valid", 36'(tx_valid), 36'd1);
    tx_ready = 1'b1;
    tick();
    tx_ready = 1'b0;
    coni();
    check("coni_out_done", io_datar, 36'o13);
    check("pi_level3", 36'(pi_vec), 36'b0010000);

    // Input a character.
    cono(36'o13);
    rx_valid = 1'b1; rx_data = 8'h5a;
    tick();
    rx_valid = 1'b0;
    coni();
    check("coni_in_done", io_datar, 36'o43);
    datai();
    check("datai_byte", io_datar, 36'o132);
    coni();
    check("coni_after_datai", io_datar, 36'o03);

    // DATAO while busy, then clear-all mid-send.
    datao(36'o101);
    datao(36'o102);
    check("busy_datao_ack", 36'(io_ack), 36'd1);
    check("busy_datao_keep", 36'(tx_data), 36'o101);
    cono(36'o400);
    check("clrall_keeps_valid", 36'(tx_valid), 36'd1);
    tick();
    tx_ready = 1'b1;
    tick();
    tx_ready = 1'b0;
    check("clrall_send_done", 36'(tx_valid), 36'd0);
    coni();
    check("coni_after_clrall", io_datar, 36'd0);

    // Second byte while input done is still set.
    rx_valid = 1'b1; rx_data = 8'h5a;
    tick();
    rx_data = 8'h11;
    tick();
    check("rx_ready_2nd", 36'(rx_ready), OvrEn ? 36'd1 : 36'd0);
    rx_valid = 1'b0;
    coni();
    check("coni_overrun", io_datar, OvrEn ? 36'o1040 : 36'o40);
    datai();
    check("datai_2nd", io_datar, OvrEn ? 36'o21 : 36'o132);

    // Wrong device code is ignored.
    strobe(1'b1, 7'o025, 1'b1, '0);
    check("other_dev_ack", 36'(io_ack), 36'd0);
    check("other_dev_data", io_datar, 36'd0);

    // Reset while a character is being offered.
    datao(36'o55);
    check("pre_reset_valid", 36'(tx_valid), 36'd1);
    #2 reset_n = 1'b0;
    #1;
    check("reset_tx_valid", 36'(tx_valid), 36'd0);
    check("reset_rx_ready", 36'(rx_ready), 36'd1);
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
    compare_all();

    // Random traffic.
    for (int n = 0; n < 3000; n++) begin
      tx_ready = ($urandom_range(2) == 0);
      rx_valid = ($urandom_range(3) == 0);
      rx_data  = 8'($urandom);
      if ($urandom_range(2) == 0) begin
        logic [6:0] d;
        bit c;
        d = ($urandom_range(7) == 0) ? 7'($urandom) : Dev;
        c = 1'($urandom);
        io_dev = {9'd0, d, 1'b0, c};
        if ($urandom_range(15) == 0) io_dev[$urandom_range(16)] = 1'b1;
        wv = {4'($urandom), 32'($urandom)};
        wv[8] = ($urandom_range(15) == 0);
        io_dataw = wv;
        if ($urandom_range(1) == 0) io_read = 1'b1;
        else io_write = 1'b1;
      end
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
